// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO for the E stage.
// Results are computed on accept, held in pend_hi/pend_lo, and committed after the busy period.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDU_out
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    logic [63:0] prod_s, prod_u, result;
    logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
    logic [31:0] qs_mag, rs_mag, q_s, r_s;
    logic        is_mdu_op;

    assign is_mdu_op = (MDUop >= OP_MULT) && (MDUop <= OP_DIVU);
    assign busy      = (state_q == RUN);
    assign start     = is_mdu_op && !busy;

    always_comb begin
        MDU_out = 32'd0;
        if (MDUop == OP_MFHI)      MDU_out = hi_q;
        else if (MDUop == OP_MFLO) MDU_out = lo_q;
    end

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
    always_comb begin
        prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u     = {32'd0, A} * {32'd0, B};
        a_mag      = A[31] ? -A : A;
        b_mag      = B[31] ? -B : B;
        b_mag_safe = (B == 32'd0) ? 32'd1 : b_mag;
        b_safe     = (B == 32'd0) ? 32'd1 : B;
        qs_mag     = a_mag / b_mag_safe;
        rs_mag     = a_mag % b_mag_safe;
        q_s        = (A[31] ^ B[31]) ? -qs_mag : qs_mag;
        r_s        = A[31] ? -rs_mag : rs_mag;
        result     = {hi_q, lo_q};
        case (MDUop)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   if (B != 32'd0) result = {r_s, q_s};
            OP_DIVU:  if (B != 32'd0) result = {A % b_safe, A / b_safe};
            default:  result = {hi_q, lo_q};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d                = RUN;
                    {pend_hi_d, pend_lo_d} = result;
                    cnt_d = (MDUop == OP_MULT || MDUop == OP_MULTU) ? CW'(MULT_CYCLES)
                                                                     : CW'(DIV_CYCLES);
                end else if (MDUop == OP_MTHI) begin
                    hi_d = A;
                end else if (MDUop == OP_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end
endmodule
